// File: rtl/mem_bank_amo.sv
// Per-bank adapter between one converter lane and a single-port SRAM with one-cycle read latency.
// Plain accesses pass through; AXI5 atomics run as a two-cycle read-modify-write inside the bank.
module mem_bank_amo #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumBanks  = 4,
   parameter int unsigned NumWords  = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         mem_req_i,
   output logic                         mem_gnt_o,
   input  logic [AddrWidth-1:0]         mem_addr_i,
   input  logic [DataWidth-1:0]         mem_wdata_i,
   input  logic [DataWidth/8-1:0]       mem_strb_i,
   input  logic [5:0]                   mem_atop_i,
   input  logic                         mem_we_i,
   output logic                         mem_rvalid_o,
   output logic [DataWidth-1:0]         mem_rdata_o,
   output logic                         sram_req_o,
   output logic                         sram_we_o,
   output logic [$clog2(NumWords)-1:0]  sram_addr_o,
   output logic [DataWidth-1:0]         sram_wdata_o,
   output logic [DataWidth/8-1:0]       sram_be_o,
   input  logic [DataWidth-1:0]         sram_rdata_i,
   output logic                         busy_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned ByteBits  = $clog2(StrbWidth);
   localparam int unsigned BankBits  = $clog2(NumBanks);
   localparam int unsigned IdxWidth  = $clog2(NumWords);

   typedef enum logic {
      IDLE,
      AMO_WR
   } state_e;

   state_e                 state_q, state_d;
   logic [DataWidth-1:0]   operand_q;
   logic [StrbWidth-1:0]   strb_q;
   logic [2:0]             op_q;
   logic                   swap_q;
   logic [IdxWidth-1:0]    idx_q;
   logic                   rvalid_q;
   logic                   rsp_read_q;

   logic [IdxWidth-1:0]    req_idx;
   logic                   is_swap;
   logic                   is_amo;
   logic                   is_plain_write;
   logic                   grant;
   logic [DataWidth-1:0]   amo_result;

   // Bank-select, byte-offset and upper address bits never reach the SRAM.
   logic unused_addr;
   assign unused_addr = ^mem_addr_i;

   assign req_idx = mem_addr_i[ByteBits+BankBits +: IdxWidth];

   // Compare and any other 11xxxx encoding fall through as a plain read without write.
   assign is_swap        = (mem_atop_i == 6'b110000);
   assign is_amo         = (mem_atop_i[5:4] == 2'b01) || (mem_atop_i[5:4] == 2'b10) || is_swap;
   assign is_plain_write = (mem_atop_i[5:4] == 2'b00) && mem_we_i;

   assign grant = rst_ni && mem_req_i && (state_q == IDLE);

   // NOTE: reset is synchronous, so it lives inside the clocked block and is not in the sensitivity list.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments so all registers update together.
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant && is_amo) state_d = AMO_WR;
         AMO_WR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         operand_q  <= '0;
         strb_q     <= '0;
         op_q       <= '0;
         swap_q     <= 1'b0;
         idx_q      <= '0;
         rvalid_q   <= 1'b0;
         rsp_read_q <= 1'b0;
      end else begin
         if (grant && is_amo) begin
            operand_q <= mem_wdata_i;
            strb_q    <= mem_strb_i;
            op_q      <= mem_atop_i[2:0];
            swap_q    <= is_swap;
            idx_q     <= req_idx;
         end
         rvalid_q   <= grant;
         rsp_read_q <= grant && !is_plain_write;
      end
   end

   // Old word arrives from the SRAM in the AMO_WR cycle.
   always_comb begin
      amo_result = operand_q;
      if (!swap_q) begin
         case (op_q)
            3'b000:  amo_result = sram_rdata_i + operand_q;
            3'b001:  amo_result = sram_rdata_i & ~operand_q;
            3'b010:  amo_result = sram_rdata_i ^ operand_q;
            3'b011:  amo_result = sram_rdata_i | operand_q;
            3'b100:  amo_result = ($signed(sram_rdata_i) > $signed(operand_q)) ? sram_rdata_i : operand_q;
            3'b101:  amo_result = ($signed(sram_rdata_i) < $signed(operand_q)) ? sram_rdata_i : operand_q;
            3'b110:  amo_result = (sram_rdata_i > operand_q) ? sram_rdata_i : operand_q;
            default: amo_result = (sram_rdata_i < operand_q) ? sram_rdata_i : operand_q;
         endcase
      end
   end

   always_comb begin
      mem_gnt_o    = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = req_idx;
      sram_wdata_o = mem_wdata_i;
      sram_be_o    = mem_strb_i;
      if (rst_ni) begin
         case (state_q)
            IDLE: begin
               mem_gnt_o  = mem_req_i;
               sram_req_o = mem_req_i;
               sram_we_o  = is_plain_write;
               if (is_amo) sram_be_o = '1;
            end
            AMO_WR: begin
               sram_req_o   = 1'b1;
               sram_we_o    = 1'b1;
               sram_addr_o  = idx_q;
               sram_wdata_o = amo_result;
               sram_be_o    = strb_q;
            end
            default: ;
         endcase
      end
   end

   // Reset drops any response already in flight, including the atomic's.
   assign mem_rvalid_o = rvalid_q && rst_ni;
   assign mem_rdata_o  = (rsp_read_q && rst_ni) ? sram_rdata_i : '0;
   assign busy_o       = rst_ni && ((state_q == AMO_WR) || rvalid_q);

endmodule

// File: tb/tb_mem_bank_amo.sv
// Directed bench for mem_bank_amo: plain accesses, atomics, hazards and reset during AMO_WR.
// Inputs change 1 time unit after posedge; outputs are checked at the following negedge.
module tb_mem_bank_amo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, gnt, we, rvalid;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  strb;
   logic [5:0]  atop;
   logic        sram_req, sram_we, busy;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata, sram_rdata;
   logic [3:0]  sram_be;

   logic [31:0] sram_mem [0:1023];

   int checks = 0;
   int errors = 0;
   int n_gnt  = 0;
   int n_rv   = 0;

   always #5 clk = ~clk;

   mem_bank_amo #(
      .AddrWidth(32), .DataWidth(32), .NumBanks(4), .NumWords(1024)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_req_i    (req),
      .mem_gnt_o    (gnt),
      .mem_addr_i   (addr),
      .mem_wdata_i  (wdata),
      .mem_strb_i   (strb),
      .mem_atop_i   (atop),
      .mem_we_i     (we),
      .mem_rvalid_o (rvalid),
      .mem_rdata_o  (rdata),
      .sram_req_o   (sram_req),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_be_o    (sram_be),
      .sram_rdata_i (sram_rdata),
      .busy_o       (busy)
   );

   // SRAM model: byte-enabled write, one-cycle read latency.
   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   always @(negedge clk) begin
      if (gnt === 1'b1)    n_gnt++;
      if (rvalid === 1'b1) n_rv++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Presents one request in the current cycle, checks the grant and SRAM access, leaves req low.
   task automatic issue(input logic w, input logic [5:0] op, input logic [9:0] idx,
                        input logic [31:0] extra, input logic [31:0] data,
                        input logic [3:0] be, input string tag);
      logic exp_we;
      exp_we = (op[5:4] == 2'b00) && w;
      req   = 1'b1;
      we    = w;
      atop  = op;
      addr  = {18'b0, idx, 4'b0} | extra;
      wdata = data;
      strb  = be;
      @(negedge clk);
      check({tag, " gnt"}, gnt, 1'b1);
      check({tag, " sram_req"}, sram_req, 1'b1);
      check({tag, " sram_we"}, sram_we, exp_we);
      check({tag, " sram_addr"}, sram_addr, idx);
      next_cycle();
      req  = 1'b0;
      we   = 1'b0;
      atop = 6'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic [31:0] exp);
      @(negedge clk);
      check({tag, " rvalid"}, rvalid, 1'b1);
      check({tag, " rdata"}, rdata, exp);
      next_cycle();
   endtask

   task automatic wr(input logic [9:0] idx, input logic [31:0] data);
      issue(1'b1, 6'b0, idx, 32'h0, data, 4'hf, "wr");
      expect_rsp("wr", 32'h0);
   endtask

   task automatic rd(input logic [9:0] idx, input logic [31:0] exp, input string tag);
      issue(1'b0, 6'b0, idx, 32'h0, 32'h0, 4'hf, tag);
      expect_rsp(tag, exp);
   endtask

   // Atomic: grant cycle, then AMO_WR cycle carrying the old-data response and the SRAM write.
   task automatic amo(input logic [5:0] op, input logic [9:0] idx, input logic [31:0] operand,
                      input logic [3:0] be, input logic [31:0] exp_old, input string tag);
      issue(1'b1, op, idx, 32'h0, operand, be, tag);
      @(negedge clk);
      check({tag, " amo gnt"}, gnt, 1'b0);
      check({tag, " amo busy"}, busy, 1'b1);
      check({tag, " amo sram_we"}, sram_we, 1'b1);
      check({tag, " amo sram_be"}, sram_be, be);
      check({tag, " amo rvalid"}, rvalid, 1'b1);
      check({tag, " amo rdata"}, rdata, exp_old);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req   = 1'b0;
      we    = 1'b0;
      atop  = 6'b0;
      addr  = 32'h0;
      wdata = 32'h0;
      strb  = 4'h0;

      // Reset: outputs quiet even with a request pending.
      repeat (2) @(posedge clk);
      #1;
      req = 1'b1;
      @(negedge clk);
      check("rst gnt", gnt, 1'b0);
      check("rst sram_req", sram_req, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst rvalid", rvalid, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      req   = 1'b0;
      @(negedge clk);
      check("post-rst rvalid", rvalid, 1'b0);
      check("post-rst rdata", rdata, 32'h0);
      check("post-rst busy", busy, 1'b0);
      next_cycle();

      // Plain write then read; the read uses nonzero bank/offset/upper address bits.
      issue(1'b1, 6'b0, 10'd5, 32'h0, 32'h1234_5678, 4'hf, "wr5");
      expect_rsp("wr5", 32'h0);
      issue(1'b0, 6'b0, 10'd5, 32'h0010_0007, 32'h0, 4'hf, "rd5");
      expect_rsp("rd5", 32'h1234_5678);

      // Partial-strobe write.
      issue(1'b1, 6'b0, 10'd5, 32'h0, 32'hAABB_CCDD, 4'b0100, "wr5 strb");
      expect_rsp("wr5 strb", 32'h0);
      rd(10'd5, 32'h12BB_5678, "rd5 strb");

      // Back-to-back write then read of the same word: read sees the new data.
      req = 1'b1; we = 1'b1; atop = 6'b0; addr = {18'b0, 10'd6, 4'b0};
      wdata = 32'hCAFE_BABE; strb = 4'hf;
      @(negedge clk);
      check("b2b wr gnt", gnt, 1'b1);
      next_cycle();
      we = 1'b0; wdata = 32'h0;
      @(negedge clk);
      check("b2b rd gnt", gnt, 1'b1);
      check("b2b wr rvalid", rvalid, 1'b1);
      check("b2b wr rdata", rdata, 32'h0);
      next_cycle();
      req = 1'b0;
      @(negedge clk);
      check("b2b rd rvalid", rvalid, 1'b1);
      check("b2b rd rdata", rdata, 32'hCAFE_BABE);
      check("b2b rd busy", busy, 1'b1);
      next_cycle();

      // AtomicLoad ADD.
      wr(10'd3, 32'd10);
      amo(6'b100000, 10'd3, 32'd5, 4'hf, 32'd10, "ldadd");
      rd(10'd3, 32'd15, "rd3 add");

      // AtomicStore SET, then CLR; atomics return the old word.
      amo(6'b010011, 10'd3, 32'h100, 4'hf, 32'd15, "stset");
      rd(10'd3, 32'h10F, "rd3 set");
      amo(6'b010001, 10'd3, 32'h5, 4'hf, 32'h10F, "stclr");
      rd(10'd3, 32'h10A, "rd3 clr");

      // Compare is unsupported: plain read, no write.
      issue(1'b1, 6'b110001, 10'd3, 32'h0, 32'hFFFF_FFFF, 4'hf, "cmp");
      expect_rsp("cmp", 32'h10A);
      rd(10'd3, 32'h10A, "rd3 cmp");

      // Signed/unsigned max/min.
      wr(10'd0, 32'hFFFF_FFFE);
      amo(6'b100100, 10'd0, 32'd1, 4'hf, 32'hFFFF_FFFE, "smax");
      rd(10'd0, 32'd1, "rd0 smax");
      wr(10'd0, 32'hFFFF_FFFE);
      amo(6'b100110, 10'd0, 32'd1, 4'hf, 32'hFFFF_FFFE, "umax");
      rd(10'd0, 32'hFFFF_FFFE, "rd0 umax");
      amo(6'b100101, 10'd0, 32'h8000_0000, 4'hf, 32'hFFFF_FFFE, "smin");
      rd(10'd0, 32'h8000_0000, "rd0 smin");

      // Swap with partial strobe keeps the upper bytes.
      wr(10'd7, 32'h0000_00A5);
      amo(6'b110000, 10'd7, 32'h0000_005A, 4'b0011, 32'h0000_00A5, "swap7");
      rd(10'd7, 32'h0000_005A, "rd7 swap");
      wr(10'd8, 32'hCAFE_00A5);
      amo(6'b110000, 10'd8, 32'h1111_225A, 4'b0011, 32'hCAFE_00A5, "swap8");
      rd(10'd8, 32'hCAFE_225A, "rd8 swap");

      // AtomicLoad followed by a read held high through AMO_WR.
      wr(10'd9, 32'd100);
      req = 1'b1; we = 1'b1; atop = 6'b100000; addr = {18'b0, 10'd9, 4'b0};
      wdata = 32'd1; strb = 4'hf;
      @(negedge clk);
      check("hold amo gnt", gnt, 1'b1);
      next_cycle();
      we = 1'b0; atop = 6'b0; wdata = 32'h0;
      @(negedge clk);
      check("hold amowr gnt", gnt, 1'b0);
      check("hold amo rvalid", rvalid, 1'b1);
      check("hold amo rdata", rdata, 32'd100);
      next_cycle();
      @(negedge clk);
      check("hold rd gnt", gnt, 1'b1);
      check("hold idle rvalid", rvalid, 1'b0);
      next_cycle();
      req = 1'b0;
      @(negedge clk);
      check("hold rd rvalid", rvalid, 1'b1);
      check("hold rd rdata", rdata, 32'd101);
      next_cycle();
      @(negedge clk);
      check("rvalid count vs grants", n_rv, n_gnt);
      next_cycle();

      // Reset during AMO_WR: no write, no response.
      wr(10'd10, 32'h77);
      issue(1'b1, 6'b100000, 10'd10, 32'h0, 32'd1, 4'hf, "rstamo");
      rst_n = 1'b0;
      @(negedge clk);
      check("rstamo sram_req", sram_req, 1'b0);
      check("rstamo rvalid", rvalid, 1'b0);
      check("rstamo busy", busy, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rstamo post busy", busy, 1'b0);
      check("rstamo post rvalid", rvalid, 1'b0);
      next_cycle();
      rd(10'd10, 32'h77, "rd10 rstamo");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bank_amo.md
# mem_bank_amo

Per-bank memory adapter between one output lane of the interleaved AXI-to-memory converter and a single-port SRAM macro with one-cycle read latency. Plain reads and writes pass through. AXI5 atomic operations arriving on the `atop` lane run as an atomic read-modify-write inside the bank. One instance is placed per bank, so atomics are serialised at the memory and need no lock in the converter.

## Interface
- `AddrWidth`, default 32: width of the byte address from the converter.
- `DataWidth`, default 32: bank word width; must be 32 or 64.
- `NumBanks`, default 4: interleave factor; a power of two, 1 allowed.
- `NumWords`, default 1024: SRAM depth in words; a power of two.
- `clk_i` in, 1: clock. One clock domain.
- `rst_ni` in, 1: reset, synchronous, active-low.
- `mem_req_i` in, 1: request valid.
- `mem_gnt_o` out, 1: request accepted.
- `mem_addr_i` in, AddrWidth: byte address.
- `mem_wdata_i` in, DataWidth: write data, or atomic operand.
- `mem_strb_i` in, DataWidth/8: byte strobe.
- `mem_atop_i` in, 6: AXI atop encoding.
- `mem_we_i` in, 1: write enable.
- `mem_rvalid_o` out, 1: response valid. There is no ready; the consumer always accepts.
- `mem_rdata_o` out, DataWidth: response data.
- `sram_req_o` out, 1: SRAM access enable.
- `sram_we_o` out, 1: SRAM write.
- `sram_addr_o` out, log2(NumWords): SRAM word index.
- `sram_wdata_o` out, DataWidth: SRAM write data.
- `sram_be_o` out, DataWidth/8: SRAM byte enable.
- `sram_rdata_i` in, DataWidth: SRAM read data, valid one cycle after a read.
- `busy_o` out, 1: high while an atomic is in flight or a response is pending.

## Operation
- **Word index:** `mem_addr_i[B+K +: log2(NumWords)]`, where B = log2(DataWidth/8) and K = log2(NumBanks). The bank-select and byte-offset bits are dropped. Address bits above the index are ignored.
- **Classification:**
  - Plain access: atop[5:4] = 00.
  - AtomicStore: atop[5:4] = 01.
  - AtomicLoad: atop[5:4] = 10.
  - Swap: atop = 110000.
  - Compare (110001) is unsupported. It is executed as a plain read with no write, and the old data is returned.
- **States:** IDLE and AMO_WR.
- **In IDLE:**
  - `mem_gnt_o = mem_req_i`, combinationally.
  - On a grant, the SRAM is accessed in the same cycle.
  - A plain write drives `sram_we_o = 1` with `sram_be_o = mem_strb_i`.
  - A plain read drives `sram_we_o = 0`.
  - An atomic first issues a read. Its wdata, strb and op are registered, the word index is held, and the state moves to AMO_WR.
- **In AMO_WR:**
  - `mem_gnt_o = 0`.
  - The new value is computed from `sram_rdata_i` (old) and the registered operand.
  - The SRAM write is issued with the registered strb as byte enable.
  - The state returns to IDLE next cycle.
- **Operations, by atop[2:0]:**
  - 000: ADD, modulo 2^DataWidth.
  - 001: CLR, old & ~op.
  - 010: EOR, old ^ op.
  - 011: SET, old | op.
  - 100: SMAX.
  - 101: SMIN.
  - 110: UMAX.
  - 111: UMIN.
  - Swap writes op.
  - Signed compares are two's complement over the full word.
- **Responses:** every granted request, including writes and atomics, produces exactly one `mem_rvalid_o` pulse.
  - Reads and atomics return the old word.
  - Writes return `mem_rdata_o = 0`.
  - The upstream routing FIFO pops on every rvalid, so this one-pulse rule must hold without exception.

## Timing
- **Reset values:** state IDLE; `mem_rvalid_o` 0; `mem_rdata_o` 0; registered operand 0.
- **While `rst_ni = 0`:** `busy_o` is 0, and `sram_req_o` and `mem_gnt_o` are 0.
- **Latency:** rvalid is asserted exactly one cycle after the grant for every access type.
- **Atomic response:** rvalid appears in the AMO_WR cycle, with old data driven from `sram_rdata_i`.
- **Throughput:**
  - Plain accesses: one per cycle.
  - Atomic: occupies 2 cycles; the next grant comes no earlier than the cycle after AMO_WR.
- **Back-to-back hazards:**
  - A plain read one cycle after a write to the same word returns the new data. The SRAM has write-first ordering across cycles.
  - A request arriving during AMO_WR is held (gnt = 0) and granted in the following IDLE cycle. It observes the atomic's result.
- **Reset mid-operation:**
  - Reset asserted in AMO_WR aborts the SRAM write (`sram_req_o = 0`) and suppresses rvalid.
  - Any pending plain response is dropped.
- **Request stability:** `mem_req_i` may deassert without a grant, because only IDLE grants and IDLE always grants.

## Test plan
- Write 0x1234_5678 with strb 1111 to word 5, then read word 5. Expect rvalid 1 cycle after each grant, data 0 for the write, then 0x1234_5678.
- Word 3 = 10; AtomicLoad ADD (atop 100000) with op 5. Expect the response to return 10, gnt low in the following cycle, and a later read of word 3 to return 15.
- Word 0 = 0xFFFF_FFFE; SMAX with op 1 → stored 1. UMAX with op 1 on 0xFFFF_FFFE → unchanged. SMIN with op 0x8000_0000 → stored 0x8000_0000.
- Swap on word 7 (old 0xA5) with op 0x5A and strb 0011 → returns 0xA5; word becomes 0x0000_005A, with the upper bytes unchanged.
- AtomicLoad followed by a continuously held read of the same word → the read is granted 2 cycles after the atomic and returns the post-atomic value. The number of rvalid pulses equals the number of grants.
- Assert `rst_ni` low during AMO_WR → no SRAM write and no rvalid. After release, `busy_o` is 0 and the word still holds its old value.
